div_sequencer: RTL

- Multi-cycle controller for the iterative divider in the execute stage.
- Accepts DIV/DIVU/REM/REMU ops from ID/EX, prepares 33-bit operands and pulses start to the divider core.
- Stalls the pipeline until the core reports done, then presents the 32-bit quotient or remainder for one cycle.
- Resolves divide-by-zero and signed overflow locally, without starting the core.
- Aborts cleanly on pipeline flush.

---
 rtl/div_sequencer_pkg.sv | 48 ++++
 rtl/div_special_detect.sv | 48 ++++
 rtl/div_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: ALU op codes, FSM state
// encodings and small op-decode helpers.
package div_sequencer_pkg;

  localparam int ALU_OP_WIDTH = 5;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 5'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 5'd13;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 5'd14;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 5'd15;

  typedef enum logic [1:0] {
    DIVSEQ_IDLE = 2'd0,
    DIVSEQ_BUSY = 2'd1,
    DIVSEQ_DONE = 2'd2
  } divseq_state_e;

  // Quotient returned for a zero divisor (all ones, matches RISC-V semantics).
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  function automatic logic is_div_op(input logic [ALU_OP_WIDTH-1:0] op);
    logic hit;
    case (op)
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: hit = 1'b1;
      default:                              hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_signed_op(input logic [ALU_OP_WIDTH-1:0] op);
    logic hit;
    case (op)
      ALU_DIV, ALU_REM: hit = 1'b1;
      default:          hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_rem_op(input logic [ALU_OP_WIDTH-1:0] op);
    logic hit;
    case (op)
      ALU_REM, ALU_REMU: hit = 1'b1;
      default:           hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/div_special_detect.sv
// Combinational detection of divide cases resolved without the core:
// zero divisor and signed overflow (most-negative / -1). Returns the
// architecturally defined quotient or remainder for those cases.
module div_special_detect
  import div_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   s1,
  input  logic [DATA_WIDTH-1:0]   s2,
  output logic                    special,
  output logic [DATA_WIDTH-1:0]   result
);

  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};

  logic zero_div_s;
  logic overflow_s;
  logic rem_s;

  // Classify the operand pair and pick the canned result.
  always_comb begin
    rem_s      = is_rem_op(op);
    zero_div_s = (s2 == ZERO);
    overflow_s = is_signed_op(op) & (s1 == MOST_NEG) & (s2 == ALL_ONES);
    special    = zero_div_s | overflow_s;
    result     = ZERO;
    if (zero_div_s) begin
      if (rem_s) begin
        result = s1;
      end else begin
        result = ALL_ONES;
      end
    end else if (overflow_s) begin
      if (rem_s) begin
        result = ZERO;
      end else begin
        result = MOST_NEG;
      end
    end else begin
      result = ZERO;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle controller for the iterative divider in EX. Launches the core
// for DIV/DIVU/REM/REMU, stalls the pipeline until done, resolves
// divide-by-zero and signed overflow locally, aborts on flush or timeout.
// Optional result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ALU_OP_WIDTH-1:0] IDEX_AluOp,
  input  logic                    op_valid,
  input  logic [DATA_WIDTH-1:0]   s1,
  input  logic [DATA_WIDTH-1:0]   s2,
  input  logic                    flush,
  output logic [DATA_WIDTH:0]     div_s1,
  output logic [DATA_WIDTH:0]     div_s2,
  output logic                    div_start,
  output logic                    div_kill,
  input  logic                    div_done,
  input  logic [DATA_WIDTH:0]     div_quotient,
  input  logic [DATA_WIDTH:0]     div_remainder,
  output logic                    Div_StallReq,
  output logic [DATA_WIDTH-1:0]   Div_Result,
  output logic                    Div_ResultValid,
  output logic                    Div_Timeout
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] RES_ZERO  = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH:0]   OPD_ZERO  = {(DATA_WIDTH+1){1'b0}};

  divseq_state_e         state_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic [CNT_WIDTH-1:0]  cnt_inc_s;
  logic                  sel_rem_r;
  logic                  sgn_r;
  logic                  result_valid_r;

  logic                  is_div_s;
  logic                  sgn_op_s;
  logic                  rem_op_s;
  logic [DATA_WIDTH:0]   ext_s1_s;
  logic [DATA_WIDTH:0]   ext_s2_s;
  logic                  special_s;
  logic [DATA_WIDTH-1:0] special_result_s;
  logic                  busy_s;
  logic                  capture_s;
  logic                  timeout_s;
  logic [DATA_WIDTH-1:0] core_result_s;
  logic                  cache_hit_s;
  logic [DATA_WIDTH-1:0] cache_result_s;
  logic                  unused_s;

  // The core's 33-bit results carry a sign-extension bit that the 32-bit
  // result never needs.
  assign unused_s = ^{div_quotient[DATA_WIDTH], div_remainder[DATA_WIDTH]};

  div_special_detect #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_special (
    .op     (IDEX_AluOp),
    .s1     (s1),
    .s2     (s2),
    .special(special_s),
    .result (special_result_s)
  );

  // Decode the incoming op and build the 33-bit core operands.
  always_comb begin
    is_div_s = op_valid & is_div_op(IDEX_AluOp);
    sgn_op_s = is_signed_op(IDEX_AluOp);
    rem_op_s = is_rem_op(IDEX_AluOp);
    if (sgn_op_s) begin
      ext_s1_s = {s1[DATA_WIDTH-1], s1};
      ext_s2_s = {s2[DATA_WIDTH-1], s2};
    end else begin
      ext_s1_s = {1'b0, s1};
      ext_s2_s = {1'b0, s2};
    end
  end

  // BUSY-state events; flush always takes priority over done and timeout.
  always_comb begin
    busy_s    = (state_r == DIVSEQ_BUSY);
    cnt_inc_s = cnt_r + CNT_ONE;
    capture_s = busy_s & ~flush & div_done;
    timeout_s = busy_s & ~flush & ~div_done & (cnt_inc_s == CNT_LIMIT);
    if (sel_rem_r) begin
      core_result_s = div_remainder[DATA_WIDTH-1:0];
    end else begin
      core_result_s = div_quotient[DATA_WIDTH-1:0];
    end
  end

  assign Div_StallReq    = ((state_r == DIVSEQ_IDLE) & is_div_s & ~flush) | busy_s;
  assign Div_ResultValid = result_valid_r & ~flush;

`ifdef DIV_RESULT_CACHE_EN
  logic                  cache_valid_r;
  logic                  cache_sgn_r;
  logic [DATA_WIDTH-1:0] cache_s1_r;
  logic [DATA_WIDTH-1:0] cache_s2_r;
  logic [DATA_WIDTH-1:0] cache_quot_r;
  logic [DATA_WIDTH-1:0] cache_rem_r;

  // Remember the last core-computed result; drop it on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_r <= 1'b0;
      cache_sgn_r   <= 1'b0;
      cache_s1_r    <= RES_ZERO;
      cache_s2_r    <= RES_ZERO;
      cache_quot_r  <= RES_ZERO;
      cache_rem_r   <= RES_ZERO;
    end else if (capture_s) begin
      cache_valid_r <= 1'b1;
      cache_sgn_r   <= sgn_r;
      cache_s1_r    <= div_s1[DATA_WIDTH-1:0];
      cache_s2_r    <= div_s2[DATA_WIDTH-1:0];
      cache_quot_r  <= div_quotient[DATA_WIDTH-1:0];
      cache_rem_r   <= div_remainder[DATA_WIDTH-1:0];
    end else if (timeout_s) begin
      cache_valid_r <= 1'b0;
    end else begin
      cache_valid_r <= cache_valid_r;
    end
  end

  // Match the request key against the cached entry.
  always_comb begin
    cache_hit_s = cache_valid_r & (cache_sgn_r == sgn_op_s) &
                  (cache_s1_r == s1) & (cache_s2_r == s2);
    if (rem_op_s) begin
      cache_result_s = cache_rem_r;
    end else begin
      cache_result_s = cache_quot_r;
    end
  end
`else
  assign cache_hit_s    = 1'b0;
  assign cache_result_s = RES_ZERO;
`endif

  // Sequencer FSM with registered core handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= DIVSEQ_IDLE;
      cnt_r          <= CNT_ZERO;
      sel_rem_r      <= 1'b0;
      sgn_r          <= 1'b0;
      result_valid_r <= 1'b0;
      div_s1         <= OPD_ZERO;
      div_s2         <= OPD_ZERO;
      div_start      <= 1'b0;
      div_kill       <= 1'b0;
      Div_Result     <= RES_ZERO;
      Div_Timeout    <= 1'b0;
    end else begin
      div_start      <= 1'b0;
      div_kill       <= 1'b0;
      result_valid_r <= 1'b0;
      case (state_r)
        DIVSEQ_IDLE: begin
          if (flush || !is_div_s) begin
            state_r <= DIVSEQ_IDLE;
          end else if (special_s) begin
            Div_Result     <= special_result_s;
            result_valid_r <= 1'b1;
            state_r        <= DIVSEQ_DONE;
          end else if (cache_hit_s) begin
            Div_Result     <= cache_result_s;
            result_valid_r <= 1'b1;
            state_r        <= DIVSEQ_DONE;
          end else begin
            div_s1    <= ext_s1_s;
            div_s2    <= ext_s2_s;
            sel_rem_r <= rem_op_s;
            sgn_r     <= sgn_op_s;
            div_start <= 1'b1;
            cnt_r     <= CNT_ZERO;
            state_r   <= DIVSEQ_BUSY;
          end
        end
        DIVSEQ_BUSY: begin
          cnt_r <= cnt_inc_s;
          if (flush) begin
            div_kill <= 1'b1;
            state_r  <= DIVSEQ_IDLE;
          end else if (capture_s) begin
            Div_Result     <= core_result_s;
            result_valid_r <= 1'b1;
            state_r        <= DIVSEQ_DONE;
          end else if (timeout_s) begin
            div_kill       <= 1'b1;
            Div_Timeout    <= 1'b1;
            Div_Result     <= RES_ZERO;
            result_valid_r <= 1'b1;
            state_r        <= DIVSEQ_DONE;
          end else begin
            state_r <= DIVSEQ_BUSY;
          end
        end
        DIVSEQ_DONE: begin
          state_r <= DIVSEQ_IDLE;
        end
        default: begin
          state_r <= DIVSEQ_IDLE;
        end
      endcase
    end
  end

endmodule
